// File: rtl/board_port_arbiter.sv
// Round-robin, burst-granular arbiter that shares the single board-memory port
// between the placer, line clearer and display reader engines.
module board_port_arbiter #(
    parameter int N_REQ        = 3,
    parameter int ROW_W        = 5,
    parameter int COL_W        = 5,
    parameter int DATA_W       = 3,
    parameter int BOARD_HEIGHT = 20,
    parameter int BOARD_WIDTH  = 10,
    parameter int NULL_CODE    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ROW_W-1:0]    rq_pos_i,
    input  logic [N_REQ*COL_W-1:0]    rq_pos_j,
    input  logic [N_REQ-1:0]          rq_read,
    input  logic [N_REQ*DATA_W-1:0]   rq_write_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      mem_en,
    output logic [ROW_W-1:0]          mem_pos_i,
    output logic [COL_W-1:0]          mem_pos_j,
    output logic                      mem_read,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rd_valid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [DATA_W-1:0] NULL_W = DATA_W'(NULL_CODE);
    localparam logic [N_REQ-1:0]  ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    last_r;
    logic [IDX_W-1:0]    owner_r;
    logic [N_REQ-1:0]    rd_tag_r;

    logic [IDX_W-1:0]    winner_s;
    logic                owner_req_s;
    logic [ROW_W-1:0]    sel_pos_i_s;
    logic [COL_W-1:0]    sel_pos_j_s;
    logic                sel_read_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                in_range_s;
    logic                cmd_ok_s;

    // First requester strictly after the previous winner, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

    // Owner's command fields and the board-bounds filter.
    always_comb begin
        winner_s    = rr_pick(req, last_r);
        owner_req_s = req[owner_r];
        sel_pos_i_s = rq_pos_i[owner_r*ROW_W +: ROW_W];
        sel_pos_j_s = rq_pos_j[owner_r*COL_W +: COL_W];
        sel_read_s  = rq_read[owner_r];
        sel_data_s  = rq_write_data[owner_r*DATA_W +: DATA_W];
        in_range_s  = ({1'b0, sel_pos_i_s} < (ROW_W+1)'(BOARD_HEIGHT)) &&
                      ({1'b0, sel_pos_j_s} < (COL_W+1)'(BOARD_WIDTH));
        if (state_r == ST_GRANT) begin
            cmd_ok_s = owner_req_s && in_range_s;
        end else begin
            cmd_ok_s = 1'b0;
        end
    end

    assign rdata = mem_rdata;

    // Ownership FSM, registered memory command and pipelined read-return tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            last_r         <= IDX_W'(N_REQ - 1);
            owner_r        <= '0;
            gnt            <= '0;
            mem_en         <= 1'b0;
            mem_pos_i      <= '0;
            mem_pos_j      <= '0;
            mem_read       <= 1'b0;
            mem_write_data <= NULL_W;
            rd_tag_r       <= '0;
            rd_valid       <= '0;
        end else begin
            rd_valid <= rd_tag_r;
            rd_tag_r <= (cmd_ok_s && sel_read_s) ? gnt : '0;
            case (state_r)
                ST_IDLE: begin
                    mem_en         <= 1'b0;
                    mem_read       <= 1'b0;
                    mem_write_data <= NULL_W;
                    if (|req) begin
                        gnt     <= ONE_HOT_0 << winner_s;
                        owner_r <= winner_s;
                        last_r  <= winner_s;
                        state_r <= ST_GRANT;
                    end else begin
                        gnt     <= '0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (owner_req_s) begin
                        // Address is captured even when filtered out.
                        mem_en         <= in_range_s;
                        mem_pos_i      <= sel_pos_i_s;
                        mem_pos_j      <= sel_pos_j_s;
                        mem_read       <= sel_read_s;
                        mem_write_data <= (in_range_s && !sel_read_s) ? sel_data_s : NULL_W;
                        state_r        <= ST_GRANT;
                    end else begin
                        gnt            <= '0;
                        mem_en         <= 1'b0;
                        mem_read       <= 1'b0;
                        mem_write_data <= NULL_W;
                        state_r        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    gnt            <= '0;
                    mem_en         <= 1'b0;
                    mem_read       <= 1'b0;
                    mem_write_data <= NULL_W;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    gnt            <= '0;
                    mem_en         <= 1'b0;
                    mem_read       <= 1'b0;
                    mem_write_data <= NULL_W;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
